// File: rtl/lc4_pkg.sv
// Shared LC4 definitions: opcode encodings, reset defaults and NZP bit positions.
package lc4_pkg;

    localparam logic [3:0] OP_BR      = 4'b0000;
    localparam logic [3:0] OP_ARITH   = 4'b0001;
    localparam logic [3:0] OP_CMP     = 4'b0010;
    localparam logic [3:0] OP_JSR     = 4'b0100;
    localparam logic [3:0] OP_LOGIC   = 4'b0101;
    localparam logic [3:0] OP_LDR     = 4'b0110;
    localparam logic [3:0] OP_STR     = 4'b0111;
    localparam logic [3:0] OP_RTI     = 4'b1000;
    localparam logic [3:0] OP_CONST   = 4'b1001;
    localparam logic [3:0] OP_SHIFT   = 4'b1010;
    localparam logic [3:0] OP_JMP     = 4'b1100;
    localparam logic [3:0] OP_HICONST = 4'b1101;
    localparam logic [3:0] OP_TRAP    = 4'b1111;

    localparam logic [15:0] RESET_PC_DEFAULT  = 16'h8200;
    localparam logic [2:0]  NZP_RESET_DEFAULT = 3'b010;

    // Bit positions inside the {N,Z,P} vector.
    typedef enum logic [1:0] {
        NZP_P = 2'd0,
        NZP_Z = 2'd1,
        NZP_N = 2'd2
    } nzp_bit_e;

endpackage

// File: rtl/lc4_nzp_gen.sv
// Classifies a 16-bit two's-complement value into a one-hot {N,Z,P} code.
module lc4_nzp_gen
    import lc4_pkg::*;
(
    input  logic [15:0] data,
    output logic [2:0]  nzp
);

    always_comb begin
        nzp = 3'b000;
        if (data[15])
            nzp[NZP_N] = 1'b1;
        else if (data == 16'h0000)
            nzp[NZP_Z] = 1'b1;
        else
            nzp[NZP_P] = 1'b1;
    end

endmodule

// File: rtl/lc4_writeback.sv
// LC4 writeback/commit stage: registers the regfile write, NZP, branch outcome and next PC.
module lc4_writeback
    import lc4_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [2:0]  NZP_RESET = NZP_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gwe,
    input  logic        i_valid,
    input  logic [15:0] i_insn,
    input  logic [15:0] i_pc,
    input  logic [15:0] i_alu_result,
    input  logic [15:0] i_dmem_data,
    output logic        o_valid,
    output logic        o_rd_we,
    output logic [2:0]  o_rd_sel,
    output logic [15:0] o_rd_data,
    output logic        o_nzp_we,
    output logic [2:0]  o_nzp,
    output logic        o_branch_taken,
    output logic [15:0] o_pc,
    output logic        o_illegal
);

    logic [3:0]  opcode;
    logic [15:0] pc1;
    logic [15:0] wb_data;
    logic [2:0]  wb_rd;
    logic        wb_we;
    logic        nzp_we;
    logic        illegal;
    logic [15:0] next_pc;
    logic [2:0]  new_nzp;

    // Immediate/offset fields were already consumed by the ALU.
    logic unused_insn_bits;
    assign unused_insn_bits = ^i_insn[8:0];

    assign opcode = i_insn[15:12];
    assign pc1    = i_pc + 16'd1;

    always_comb begin
        wb_data = i_alu_result;
        wb_rd   = i_insn[11:9];
        wb_we   = 1'b0;
        nzp_we  = 1'b0;
        illegal = 1'b0;
        next_pc = pc1;
        case (opcode)
            OP_ARITH, OP_LOGIC, OP_CONST, OP_SHIFT, OP_HICONST: begin
                wb_we  = 1'b1;
                nzp_we = 1'b1;
            end
            OP_LDR: begin
                wb_data = i_dmem_data;
                wb_we   = 1'b1;
                nzp_we  = 1'b1;
            end
            OP_JSR, OP_TRAP: begin
                wb_data = pc1;
                wb_rd   = 3'd7;
                wb_we   = 1'b1;
                nzp_we  = 1'b1;
                next_pc = i_alu_result;
            end
            OP_CMP: begin
                nzp_we = 1'b1;
            end
            OP_STR: begin
            end
            OP_RTI, OP_JMP: begin
                next_pc = i_alu_result;
            end
            // Branch tests the NZP currently held, i.e. the previous commit's result.
            OP_BR: begin
                if (|(i_insn[11:9] & o_nzp))
                    next_pc = i_alu_result;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    lc4_nzp_gen u_nzp_gen (
        .data (wb_data),
        .nzp  (new_nzp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid        <= 1'b0;
            o_rd_we        <= 1'b0;
            o_rd_sel       <= 3'd0;
            o_rd_data      <= 16'h0000;
            o_nzp_we       <= 1'b0;
            o_nzp          <= NZP_RESET;
            o_branch_taken <= 1'b0;
            o_pc           <= RESET_PC;
            o_illegal      <= 1'b0;
        end else if (gwe) begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_rd_we        <= wb_we;
                o_rd_sel       <= wb_rd;
                o_rd_data      <= wb_data;
                o_nzp_we       <= nzp_we;
                o_branch_taken <= (next_pc != pc1);
                o_pc           <= next_pc;
                o_illegal      <= illegal;
                if (nzp_we)
                    o_nzp <= new_nzp;
            end else begin
                o_rd_we        <= 1'b0;
                o_nzp_we       <= 1'b0;
                o_branch_taken <= 1'b0;
                o_illegal      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lc4_writeback.sv
// Self-checking bench for lc4_writeback: directed LC4 instruction stream against an architectural model.
module tb_lc4_writeback;

    logic        clk;
    logic        rst;
    logic        gwe;
    logic        i_valid;
    logic [15:0] i_insn;
    logic [15:0] i_pc;
    logic [15:0] i_alu_result;
    logic [15:0] i_dmem_data;
    logic        o_valid;
    logic        o_rd_we;
    logic [2:0]  o_rd_sel;
    logic [15:0] o_rd_data;
    logic        o_nzp_we;
    logic [2:0]  o_nzp;
    logic        o_branch_taken;
    logic [15:0] o_pc;
    logic        o_illegal;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    logic        m_valid, m_rd_we, m_nzp_we, m_taken, m_illegal;
    logic [2:0]  m_rd_sel, m_nzp;
    logic [15:0] m_rd_data, m_pc;

    lc4_writeback dut (
        .clk            (clk),
        .rst            (rst),
        .gwe            (gwe),
        .i_valid        (i_valid),
        .i_insn         (i_insn),
        .i_pc           (i_pc),
        .i_alu_result   (i_alu_result),
        .i_dmem_data    (i_dmem_data),
        .o_valid        (o_valid),
        .o_rd_we        (o_rd_we),
        .o_rd_sel       (o_rd_sel),
        .o_rd_data      (o_rd_data),
        .o_nzp_we       (o_nzp_we),
        .o_nzp          (o_nzp),
        .o_branch_taken (o_branch_taken),
        .o_pc           (o_pc),
        .o_illegal      (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] sign_class(input logic [15:0] d);
        if ($signed(d) < 0) return 3'b100;
        if (d == 16'h0000)  return 3'b010;
        return 3'b001;
    endfunction

    // Architectural effect of one clock edge, phrased by instruction class.
    task automatic modelStep();
        logic [15:0] fallthru, target, value;
        logic [2:0]  dest;
        bit          writes, sets_flags, bad;
        if (rst) begin
            {m_valid, m_rd_we, m_nzp_we, m_taken, m_illegal} = '0;
            m_rd_sel  = 3'd0;
            m_rd_data = 16'h0000;
            m_nzp     = 3'b010;
            m_pc      = 16'h8200;
        end else if (gwe && !i_valid) begin
            {m_valid, m_rd_we, m_nzp_we, m_taken, m_illegal} = '0;
        end else if (gwe) begin
            fallthru   = i_pc + 16'd1;
            target     = fallthru;
            value      = i_alu_result;
            dest       = i_insn[11:9];
            writes     = 0;
            sets_flags = 0;
            bad        = 0;
            case (i_insn[15:12])
                4'h1, 4'h5, 4'h9, 4'hA, 4'hD: writes = 1;
                4'h6: begin writes = 1; value = i_dmem_data; end
                4'h4, 4'hF: begin writes = 1; value = fallthru; dest = 3'd7; target = i_alu_result; end
                4'h2: sets_flags = 1;
                4'h7: ;
                4'h8, 4'hC: target = i_alu_result;
                4'h0: if ((i_insn[11] && m_nzp[2]) || (i_insn[10] && m_nzp[1]) || (i_insn[9] && m_nzp[0]))
                          target = i_alu_result;
                default: bad = 1;
            endcase
            m_valid   = 1'b1;
            m_rd_we   = writes;
            m_rd_sel  = dest;
            m_rd_data = value;
            m_nzp_we  = writes || sets_flags;
            if (m_nzp_we) m_nzp = sign_class(value);
            m_taken   = (target != fallthru);
            m_pc      = target;
            m_illegal = bad;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic g, input logic v, input logic [15:0] insn,
                                 input logic [15:0] pc, input logic [15:0] alu, input logic [15:0] dmem);
        rst = r; gwe = g; i_valid = v;
        i_insn = insn; i_pc = pc; i_alu_result = alu; i_dmem_data = dmem;
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic checkOutput();
        check("valid",   16'(o_valid),        16'(m_valid));
        check("rd_we",   16'(o_rd_we),        16'(m_rd_we));
        check("rd_sel",  16'(o_rd_sel),       16'(m_rd_sel));
        check("rd_data", o_rd_data,           m_rd_data);
        check("nzp_we",  16'(o_nzp_we),       16'(m_nzp_we));
        check("nzp",     16'(o_nzp),          16'(m_nzp));
        check("taken",   16'(o_branch_taken), 16'(m_taken));
        check("pc",      o_pc,                m_pc);
        check("illegal", 16'(o_illegal),      16'(m_illegal));
    endtask

    always @(negedge clk) if (checking) checkOutput();

    initial begin
        logic [15:0] held_pc, held_data, r;
        logic [2:0]  held_nzp;
        logic [3:0]  op;
        rst = 1'b1; gwe = 1'b0; i_valid = 1'b0;
        i_insn = '0; i_pc = '0; i_alu_result = '0; i_dmem_data = '0;
        @(negedge clk);
        applyStimulus(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        checking = 1'b1;

        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 0, 16'h1240, 16'h1111, 16'h2222, 16'h3333);
            check("idle_pc", o_pc, 16'h8200);
            check("idle_nzp", 16'(o_nzp), 16'h0002);
            check("idle_valid", 16'(o_valid), 16'h0000);
        end

        applyStimulus(0, 1, 1, 16'h1240, 16'h8200, 16'hFFFE, 16'h0000);
        check("add_rd_we", 16'(o_rd_we), 16'h0001);
        check("add_rd_sel", 16'(o_rd_sel), 16'h0001);
        check("add_rd_data", o_rd_data, 16'hFFFE);
        check("add_nzp", 16'(o_nzp), 16'h0004);
        check("add_pc", o_pc, 16'h8201);

        applyStimulus(0, 1, 1, 16'h2201, 16'h8200, 16'h0000, 16'h0000);
        check("cmp_nzp", 16'(o_nzp), 16'h0002);
        check("cmp_rd_we", 16'(o_rd_we), 16'h0000);
        applyStimulus(0, 1, 1, 16'h0405, 16'h8201, 16'h8208, 16'h0000);
        check("brz_taken", 16'(o_branch_taken), 16'h0001);
        check("brz_pc", o_pc, 16'h8208);
        applyStimulus(0, 1, 1, 16'h0205, 16'h8201, 16'h8208, 16'h0000);
        check("brp_taken", 16'(o_branch_taken), 16'h0000);
        check("brp_pc", o_pc, 16'h8202);

        applyStimulus(0, 1, 1, 16'hF025, 16'h0010, 16'h8025, 16'h0000);
        check("trap_rd_sel", 16'(o_rd_sel), 16'h0007);
        check("trap_rd_data", o_rd_data, 16'h0011);
        check("trap_nzp", 16'(o_nzp), 16'h0001);
        check("trap_pc", o_pc, 16'h8025);

        applyStimulus(0, 1, 1, 16'h6A00, 16'h8025, 16'h4000, 16'h8000);
        check("ldr_rd_data", o_rd_data, 16'h8000);
        check("ldr_nzp", 16'(o_nzp), 16'h0004);
        applyStimulus(0, 1, 1, 16'h7000, 16'h8026, 16'h0000, 16'h0000);
        applyStimulus(0, 1, 1, 16'hC1C0, 16'h1233, 16'h1234, 16'h0000);
        check("jmp_to_pc1_taken", 16'(o_branch_taken), 16'h0000);
        applyStimulus(0, 1, 1, 16'h4800, 16'h2000, 16'h3000, 16'h0000);
        applyStimulus(0, 1, 1, 16'h8000, 16'h3000, 16'h0400, 16'h0000);
        applyStimulus(0, 1, 1, 16'h0000, 16'h0400, 16'h0500, 16'h0000);
        check("br_nop_pc", o_pc, 16'h0401);
        applyStimulus(0, 1, 1, 16'h0E10, 16'h0401, 16'h0600, 16'h0000);
        check("brnzp_pc", o_pc, 16'h0600);

        held_pc = o_pc; held_data = o_rd_data; held_nzp = o_nzp;
        applyStimulus(0, 0, 1, 16'h1240, 16'h0600, 16'h0000, 16'h0000);
        check("gwe0_pc", o_pc, held_pc);
        check("gwe0_rd_data", o_rd_data, held_data);
        check("gwe0_nzp", 16'(o_nzp), 16'(held_nzp));
        applyStimulus(0, 1, 0, 16'h1240, 16'h0600, 16'h0000, 16'h0000);
        check("bubble_valid", 16'(o_valid), 16'h0000);
        check("bubble_pc", o_pc, held_pc);

        applyStimulus(0, 1, 1, 16'hB000, 16'hFFFF, 16'h1234, 16'h0000);
        check("ill_flag", 16'(o_illegal), 16'h0001);
        check("ill_rd_we", 16'(o_rd_we), 16'h0000);
        check("ill_pc_wrap", o_pc, 16'h0000);
        applyStimulus(1, 1, 1, 16'hB000, 16'hFFFF, 16'h1234, 16'h0000);
        check("rst_pc", o_pc, 16'h8200);
        check("rst_illegal", 16'(o_illegal), 16'h0000);

        // Mixed stream exercising every opcode, stalls and occasional resets.
        for (int k = 0; k < 60; k++) begin
            r  = 16'($urandom());
            op = 4'(k % 16);
            applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 5) != 0),
                          ($urandom_range(0, 4) != 0), {op, r[11:0]}, 16'($urandom()),
                          ((k % 5) == 0) ? 16'h0000 : 16'($urandom()), 16'($urandom()));
        end

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
